// File: rtl/hazard_if.sv
// rtl/hazard_if.sv - ID-stage hazard bus between the pipeline and the hazard scoreboard unit
// The master modport is the pipeline side; the slave modport is the hazard unit.
interface hazard_if #(
   parameter int NUM_REGS   = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  id_valid;
   logic [6:0]            id_opcode;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_long_lat;
   logic                  ex_mem_read;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  branch_mispredicted;
   logic                  wb_long_valid;
   logic [REG_ADDR_W-1:0] wb_long_rd;
   logic                  pc_write;
   logic                  if_id_write;
   logic                  if_id_flush;
   logic                  id_ex_flush;
   logic [NUM_REGS-1:0]   sb_busy;
   logic [3:0]            pending_cnt;

   modport master (
      output id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_long_lat,
      output ex_mem_read, ex_rd, branch_mispredicted, wb_long_valid, wb_long_rd,
      input  pc_write, if_id_write, if_id_flush, id_ex_flush, sb_busy, pending_cnt
   );

   modport slave (
      input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_long_lat,
      input  ex_mem_read, ex_rd, branch_mispredicted, wb_long_valid, wb_long_rd,
      output pc_write, if_id_write, if_id_flush, id_ex_flush, sb_busy, pending_cnt
   );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - load-use/scoreboard hazard control with mispredict flush sequencing
// Optional perf counters are enabled by defining HAZARD_PERF_COUNTERS_EN.
module hazard_scoreboard_unit #(
   parameter int NUM_REGS     = 32,
   parameter int REG_ADDR_W   = 5,
   parameter int MAX_PENDING  = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   hazard_if.slave     bus
`ifdef HAZARD_PERF_COUNTERS_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flush_cycles,
   output logic [31:0] perf_struct_stalls
`endif
);
   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t              state_q, state_d;
   logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
   logic [NUM_REGS-1:0] sb_q, sb_d;
   logic [3:0]          pending_q, pending_d;

   logic rs1_used, rs2_used, byp1, byp2;
   logic load_use, sb_hazard, waw_hazard, struct_hazard, stall;
   logic issue, complete, rd_in_range;

   function automatic logic busy_at(input logic [NUM_REGS-1:0] sb,
                                    input logic [REG_ADDR_W-1:0] idx);
      if (idx == '0 || int'(idx) >= NUM_REGS) return 1'b0;
      return sb[idx];
   endfunction

   always_comb begin
      rs1_used = !(bus.id_opcode == 7'b0110111 || bus.id_opcode == 7'b0010111 ||
                   bus.id_opcode == 7'b1101111);
      rs2_used = (bus.id_opcode == 7'b0110011 || bus.id_opcode == 7'b0100011 ||
                  bus.id_opcode == 7'b1100011);
      // write-through register file: a same-cycle long writeback satisfies the read
      byp1 = bus.wb_long_valid && bus.wb_long_rd == bus.id_rs1;
      byp2 = bus.wb_long_valid && bus.wb_long_rd == bus.id_rs2;
      complete = bus.wb_long_valid && busy_at(sb_q, bus.wb_long_rd);

      load_use = bus.id_valid && bus.ex_mem_read && bus.ex_rd != '0 &&
                 ((rs1_used && bus.id_rs1 == bus.ex_rd) ||
                  (rs2_used && bus.id_rs2 == bus.ex_rd));
      sb_hazard = bus.id_valid &&
                  ((rs1_used && busy_at(sb_q, bus.id_rs1) && !byp1) ||
                   (rs2_used && busy_at(sb_q, bus.id_rs2) && !byp2));
      waw_hazard = bus.id_valid && bus.id_long_lat && busy_at(sb_q, bus.id_rd);
      // only a real completion frees a slot, so a stray writeback cannot overfill
      struct_hazard = bus.id_valid && bus.id_long_lat &&
                      pending_q == 4'(MAX_PENDING) && !complete;
      stall = load_use || sb_hazard || waw_hazard || struct_hazard;

      rd_in_range = bus.id_rd != '0 && int'(bus.id_rd) < NUM_REGS;
      issue = bus.id_valid && bus.id_long_lat && rd_in_range && !stall &&
              state_q == IDLE && !bus.branch_mispredicted;
   end

   always_comb begin
      sb_d = sb_q;
      if (complete) sb_d[bus.wb_long_rd] = 1'b0;
      if (issue) sb_d[bus.id_rd] = 1'b1;
      sb_d[0] = 1'b0;
      pending_d = pending_q + {3'b000, issue} - {3'b000, complete};
   end

   always_comb begin
      state_d         = state_q;
      flush_cnt_d     = flush_cnt_q;
      bus.pc_write    = 1'b1;
      bus.if_id_write = 1'b1;
      bus.if_id_flush = 1'b0;
      bus.id_ex_flush = 1'b0;
      if (bus.branch_mispredicted) begin
         bus.if_id_write = 1'b0;
         bus.if_id_flush = 1'b1;
         bus.id_ex_flush = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
         end else begin
            state_d = IDLE;
         end
      end else if (state_q == FLUSH) begin
         bus.if_id_write = 1'b0;
         bus.if_id_flush = 1'b1;
         bus.id_ex_flush = 1'b1;
         flush_cnt_d     = flush_cnt_q - 1'b1;
         if (flush_cnt_q <= FC_W'(1)) state_d = IDLE;
      end else if (stall) begin
         bus.pc_write    = 1'b0;
         bus.if_id_write = 1'b0;
         bus.id_ex_flush = 1'b1;
      end
      // reset overrides the pipeline controls without waiting for a clock
      if (!rst_n) begin
         bus.pc_write    = 1'b0;
         bus.if_id_write = 1'b0;
         bus.if_id_flush = 1'b1;
         bus.id_ex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         flush_cnt_q <= '0;
         sb_q        <= '0;
         pending_q   <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         sb_q        <= sb_d;
         pending_q   <= pending_d;
      end
   end

   assign bus.sb_busy     = sb_q;
   assign bus.pending_cnt = pending_q;

`ifdef HAZARD_PERF_COUNTERS_EN
   logic stall_case;
   assign stall_case = !bus.branch_mispredicted && state_q == IDLE && stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cycles  <= '0;
         perf_flush_cycles  <= '0;
         perf_struct_stalls <= '0;
      end else begin
         if (stall_case && perf_stall_cycles != 32'hFFFF_FFFF)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (bus.if_id_flush && perf_flush_cycles != 32'hFFFF_FFFF)
            perf_flush_cycles <= perf_flush_cycles + 32'd1;
         if (struct_hazard && perf_struct_stalls != 32'hFFFF_FFFF)
            perf_struct_stalls <= perf_struct_stalls + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - directed self-checking bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [3:0] outs;

   always #5 clk = ~clk;

   hazard_if #(.NUM_REGS(32), .REG_ADDR_W(5)) bus ();

`ifdef HAZARD_PERF_COUNTERS_EN
   logic [31:0] perf_stall_cycles, perf_flush_cycles, perf_struct_stalls;
`endif

   hazard_scoreboard_unit #(
      .NUM_REGS(32), .REG_ADDR_W(5), .MAX_PENDING(4), .FLUSH_CYCLES(2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
`ifdef HAZARD_PERF_COUNTERS_EN
      ,
      .perf_stall_cycles  (perf_stall_cycles),
      .perf_flush_cycles  (perf_flush_cycles),
      .perf_struct_stalls (perf_struct_stalls)
`endif
   );

   assign outs = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.id_valid = 0; bus.id_opcode = 7'b0010011; bus.id_rs1 = 0; bus.id_rs2 = 0;
      bus.id_rd = 0; bus.id_long_lat = 0; bus.ex_mem_read = 0; bus.ex_rd = 0;
      bus.branch_mispredicted = 0; bus.wb_long_valid = 0; bus.wb_long_rd = 0;
   endtask

   task automatic drive_id(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic long_lat);
      bus.id_valid = 1; bus.id_opcode = op; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
      bus.id_rd = rd; bus.id_long_lat = long_lat;
   endtask

   task automatic test_reset();
      drive_idle();
      rst_n = 0;
      #2;
      checks++;
      if (outs !== 4'b0011) begin errors++; $display("FAIL reset_outs got %b exp 0011", outs); end
      checks++;
      if (bus.pending_cnt !== 4'd0 || bus.sb_busy !== 32'd0) begin
         errors++; $display("FAIL reset_state got cnt=%0d sb=%h exp 0/0", bus.pending_cnt, bus.sb_busy);
      end
      tick(); tick();
      rst_n = 1;
      @(negedge clk);
      checks++;
      if (outs !== 4'b1100) begin errors++; $display("FAIL post_reset_outs got %b exp 1100", outs); end
      tick();
   endtask

   task automatic test_load_use();
      drive_idle();
      bus.ex_mem_read = 1; bus.ex_rd = 5;
      drive_id(7'b0110011, 5'd0, 5'd5, 5'd3, 1'b0);
      @(negedge clk);
      checks++;
      if (outs !== 4'b0001) begin errors++; $display("FAIL load_use_rs2 got %b exp 0001", outs); end
      tick();
      drive_id(7'b0110111, 5'd5, 5'd5, 5'd3, 1'b0);
      @(negedge clk);
      checks++;
      if (outs !== 4'b1100) begin errors++; $display("FAIL load_use_lui got %b exp 1100", outs); end
      tick();
      drive_id(7'b0010011, 5'd1, 5'd5, 5'd3, 1'b0);
      @(negedge clk);
      checks++;
      if (outs !== 4'b1100) begin errors++; $display("FAIL load_use_itype_rs2 got %b exp 1100", outs); end
      tick();
      drive_idle();
   endtask

   task automatic test_scoreboard_bypass();
      drive_idle();
      drive_id(7'b0110011, 5'd1, 5'd2, 5'd7, 1'b1);
      @(negedge clk);
      checks++;
      if (outs !== 4'b1100) begin errors++; $display("FAIL sb_issue_outs got %b exp 1100", outs); end
      tick();
      drive_id(7'b0010011, 5'd7, 5'd0, 5'd8, 1'b0);
      @(negedge clk);
      checks++;
      if (outs !== 4'b0001 || bus.sb_busy !== 32'h80 || bus.pending_cnt !== 4'd1) begin
         errors++; $display("FAIL sb_stall got outs=%b sb=%h cnt=%0d exp 0001/80/1", outs, bus.sb_busy, bus.pending_cnt);
      end
      tick();
      @(negedge clk);
      checks++;
      if (outs !== 4'b0001) begin errors++; $display("FAIL sb_stall_hold got %b exp 0001", outs); end
      tick();
      bus.wb_long_valid = 1; bus.wb_long_rd = 7;
      @(negedge clk);
      checks++;
      if (outs !== 4'b1100) begin errors++; $display("FAIL sb_bypass got %b exp 1100", outs); end
      tick();
      drive_idle();
      @(negedge clk);
      checks++;
      if (bus.sb_busy !== 32'h0 || bus.pending_cnt !== 4'd0) begin
         errors++; $display("FAIL sb_complete got sb=%h cnt=%0d exp 0/0", bus.sb_busy, bus.pending_cnt);
      end
      tick();
   endtask

   task automatic test_struct();
      drive_idle();
      for (int r = 1; r <= 4; r++) begin
         drive_id(7'b0110011, 5'd0, 5'd0, 5'(r), 1'b1);
         @(negedge clk);
         checks++;
         if (outs !== 4'b1100) begin errors++; $display("FAIL struct_fill_%0d got %b exp 1100", r, outs); end
         tick();
      end
      drive_id(7'b0110011, 5'd0, 5'd0, 5'd5, 1'b1);
      @(negedge clk);
      checks++;
      if (outs !== 4'b0001 || bus.pending_cnt !== 4'd4 || bus.sb_busy !== 32'h1E) begin
         errors++; $display("FAIL struct_full got outs=%b cnt=%0d sb=%h exp 0001/4/1e", outs, bus.pending_cnt, bus.sb_busy);
      end
      tick();
      bus.wb_long_valid = 1; bus.wb_long_rd = 1;
      @(negedge clk);
      checks++;
      if (outs !== 4'b1100) begin errors++; $display("FAIL struct_release got %b exp 1100", outs); end
      tick();
      drive_idle();
      @(negedge clk);
      checks++;
      if (bus.pending_cnt !== 4'd4 || bus.sb_busy !== 32'h3C) begin
         errors++; $display("FAIL struct_swap got cnt=%0d sb=%h exp 4/3c", bus.pending_cnt, bus.sb_busy);
      end
      for (int r = 2; r <= 5; r++) begin
         tick();
         bus.wb_long_valid = 1; bus.wb_long_rd = 5'(r);
      end
      tick();
      drive_idle();
      @(negedge clk);
      checks++;
      if (bus.pending_cnt !== 4'd0 || bus.sb_busy !== 32'h0) begin
         errors++; $display("FAIL struct_drain got cnt=%0d sb=%h exp 0/0", bus.pending_cnt, bus.sb_busy);
      end
      tick();
   endtask

   task automatic test_mispredict();
      logic [3:0] exp_seq [4];
      drive_idle();
      bus.branch_mispredicted = 1;
      @(negedge clk);
      checks++;
      if (outs !== 4'b1011) begin errors++; $display("FAIL flush1_c1 got %b exp 1011", outs); end
      tick();
      bus.branch_mispredicted = 0;
      drive_id(7'b0110011, 5'd0, 5'd0, 5'd6, 1'b1);
      @(negedge clk);
      checks++;
      if (outs !== 4'b1011) begin errors++; $display("FAIL flush1_c2 got %b exp 1011", outs); end
      tick();
      drive_idle();
      @(negedge clk);
      checks++;
      if (outs !== 4'b1100 || bus.sb_busy !== 32'h0) begin
         errors++; $display("FAIL flush1_end got outs=%b sb=%h exp 1100/0", outs, bus.sb_busy);
      end
      tick();
      exp_seq[0] = 4'b1011; exp_seq[1] = 4'b1011; exp_seq[2] = 4'b1011; exp_seq[3] = 4'b1100;
      for (int c = 0; c < 4; c++) begin
         bus.branch_mispredicted = (c < 2);
         @(negedge clk);
         checks++;
         if (outs !== exp_seq[c]) begin errors++; $display("FAIL flush2_c%0d got %b exp %b", c + 1, outs, exp_seq[c]); end
         tick();
      end
      drive_idle();
   endtask

   task automatic test_same_edge();
      drive_idle();
      drive_id(7'b0110011, 5'd0, 5'd0, 5'd9, 1'b1);
      tick();
      bus.wb_long_valid = 1; bus.wb_long_rd = 9;
      @(negedge clk);
      checks++;
      if (outs !== 4'b0001) begin errors++; $display("FAIL waw_stall got %b exp 0001", outs); end
      tick();
      bus.wb_long_valid = 0;
      @(negedge clk);
      checks++;
      if (outs !== 4'b1100 || bus.sb_busy !== 32'h0 || bus.pending_cnt !== 4'd0) begin
         errors++; $display("FAIL waw_clear got outs=%b sb=%h cnt=%0d exp 1100/0/0", outs, bus.sb_busy, bus.pending_cnt);
      end
      tick();
      drive_idle();
      @(negedge clk);
      checks++;
      if (bus.sb_busy !== 32'h200 || bus.pending_cnt !== 4'd1) begin
         errors++; $display("FAIL waw_retry got sb=%h cnt=%0d exp 200/1", bus.sb_busy, bus.pending_cnt);
      end
      tick();
      bus.wb_long_valid = 1; bus.wb_long_rd = 9;
      tick();
      drive_idle();
   endtask

   task automatic test_reset_mid_flush();
      drive_idle();
      drive_id(7'b0110011, 5'd0, 5'd0, 5'd10, 1'b1);
      tick();
      drive_id(7'b0110011, 5'd0, 5'd0, 5'd11, 1'b1);
      tick();
      drive_idle();
      bus.branch_mispredicted = 1;
      tick();
      bus.branch_mispredicted = 0;
      @(negedge clk);
      checks++;
      if (outs !== 4'b1011 || bus.pending_cnt !== 4'd2) begin
         errors++; $display("FAIL pre_reset got outs=%b cnt=%0d exp 1011/2", outs, bus.pending_cnt);
      end
      #1;
      rst_n = 0;
      #1;
      checks++;
      if (outs !== 4'b0011 || bus.sb_busy !== 32'h0 || bus.pending_cnt !== 4'd0) begin
         errors++; $display("FAIL async_reset got outs=%b sb=%h cnt=%0d exp 0011/0/0", outs, bus.sb_busy, bus.pending_cnt);
      end
      tick();
      rst_n = 1;
      @(negedge clk);
      checks++;
      if (outs !== 4'b1100 || bus.sb_busy !== 32'h0 || bus.pending_cnt !== 4'd0) begin
         errors++; $display("FAIL after_reset got outs=%b sb=%h cnt=%0d exp 1100/0/0", outs, bus.sb_busy, bus.pending_cnt);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_scoreboard_bypass();
      test_struct();
      test_mispredict();
      test_same_edge();
      test_reset_mid_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
